// File: rtl/sfx_player.sv
// Sound-effect sequencer: on a playsound rising edge, plays the selected note list as a square wave.
// Latency: busy/cur_sound update on the trigger edge; first audio toggle H clocks later.
// No backpressure: a new request restarts playback immediately, and the sound being preempted emits no sound_done.
module sfx_player #(
    parameter int TICK_CYCLES = 1250000,
    parameter int PITCH_UNIT  = 1600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       playsound,
    input  logic [1:0] soundselector,
    output logic       audio_out,
    output logic       busy,
    output logic       sound_done,
    output logic [1:0] cur_sound
);
    localparam int HPW = $clog2(16 * PITCH_UNIT);
    localparam int DW  = $clog2(15 * TICK_CYCLES + 1);

    // Each entry is {pitch[2:0], len[3:0]}, indexed by {sound, note}; len 0 terminates.
    localparam logic [6:0] ROM [16] = '{
        {3'd5, 4'd1}, 7'd0,         7'd0,         7'd0,
        {3'd3, 4'd2}, {3'd5, 4'd2}, {3'd7, 4'd3}, 7'd0,
        {3'd2, 4'd2}, {3'd0, 4'd1}, {3'd1, 4'd4}, 7'd0,
        {3'd4, 4'd2}, {3'd5, 4'd2}, {3'd6, 4'd2}, {3'd7, 4'd4}
    };

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state;
    logic [1:0]        idx;
    logic [HPW-1:0]    hp_cnt;
    logic [DW-1:0]     dur_cnt;
    logic              ps_hist;

    logic              trig;
    logic [2:0]        cur_p;
    logic [3:0]        cur_len;
    logic [3:0]        nxt_len;
    logic              last_entry;
    logic [HPW-1:0]    hp_last;
    logic [DW-1:0]     dur_last;

    assign trig       = playsound && !ps_hist;
    assign cur_p      = ROM[{cur_sound, idx}][6:4];
    assign cur_len    = ROM[{cur_sound, idx}][3:0];
    assign nxt_len    = ROM[{cur_sound, idx + 2'd1}][3:0];
    assign last_entry = (idx == 2'd3) || (nxt_len == 4'd0);

    // Terminal counts are formed in int arithmetic, so the full product never overflows before narrowing.
    assign hp_last  = HPW'(PITCH_UNIT * (18 - 2 * int'(cur_p)) - 1);
    assign dur_last = DW'(int'(cur_len) * TICK_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 2'd0;
            hp_cnt     <= '0;
            dur_cnt    <= '0;
            ps_hist    <= 1'b1;
            audio_out  <= 1'b0;
            busy       <= 1'b0;
            sound_done <= 1'b0;
            cur_sound  <= 2'd0;
        end else begin
            ps_hist    <= playsound;
            sound_done <= 1'b0;
            if (trig) begin
                cur_sound <= soundselector;
                idx       <= 2'd0;
                hp_cnt    <= '0;
                dur_cnt   <= '0;
                audio_out <= 1'b0;
                busy      <= 1'b1;
                state     <= PLAY;
            end else if (state == PLAY) begin
                // Note expiry outranks a coincident half-period wrap.
                if (dur_cnt == dur_last) begin
                    hp_cnt    <= '0;
                    dur_cnt   <= '0;
                    audio_out <= 1'b0;
                    if (last_entry) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        idx        <= 2'd0;
                        sound_done <= 1'b1;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end else begin
                    dur_cnt <= dur_cnt + DW'(1);
                    if (cur_p == 3'd0) begin
                        audio_out <= 1'b0;
                    end else if (hp_cnt == hp_last) begin
                        hp_cnt    <= '0;
                        audio_out <= ~audio_out;
                    end else begin
                        hp_cnt <= hp_cnt + HPW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sfx_player.sv
// Bench for sfx_player: elapsed-time reference model checked every cycle, plus directed literal checks.
module tb_sfx_player;
    localparam int T  = 64;
    localparam int PU = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       playsound;
    logic [1:0] soundselector;
    logic       audio_out;
    logic       busy;
    logic       sound_done;
    logic [1:0] cur_sound;

    always #5 clk = ~clk;

    sfx_player #(.TICK_CYCLES(T), .PITCH_UNIT(PU)) dut (
        .clk          (clk),
        .reset        (reset),
        .playsound    (playsound),
        .soundselector(soundselector),
        .audio_out    (audio_out),
        .busy         (busy),
        .sound_done   (sound_done),
        .cur_sound    (cur_sound)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    logic aud [0:2047];

    // Note tables: pitch and length (ticks) per sound; length 0 ends the list.
    int sp [4][4] = '{'{5, 0, 0, 0}, '{3, 5, 7, 0}, '{2, 0, 1, 0}, '{4, 5, 6, 7}};
    int sl [4][4] = '{'{1, 0, 0, 0}, '{2, 2, 3, 0}, '{2, 1, 4, 0}, '{2, 2, 2, 4}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seq_total(input int s);
        int sum = 0;
        for (int i = 0; i < 4; i++) begin
            if (sl[s][i] == 0) break;
            sum += sl[s][i] * T;
        end
        return sum;
    endfunction

    // Audio level t clocks after the trigger: which note, then parity of elapsed half-periods.
    function automatic logic exp_audio(input int s, input int t);
        int start = 0;
        for (int i = 0; i < 4; i++) begin
            if (sl[s][i] == 0) break;
            if (t < start + sl[s][i] * T) begin
                if (sp[s][i] == 0) return 1'b0;
                return (((t - start) / (PU * (18 - 2 * sp[s][i]))) % 2) == 1;
            end
            start += sl[s][i] * T;
        end
        return 1'b0;
    endfunction

    logic m_hist   = 1'b1;
    logic m_active = 1'b0;
    int   m_t      = 0;
    int   m_sound  = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_hist = 1'b1; m_active = 1'b0; m_t = 0; m_sound = 0;
        end else begin
            if (playsound && !m_hist) begin
                m_sound = int'(soundselector); m_t = 0; m_active = 1'b1;
            end else if (m_active) begin
                m_t++;
                if (m_t > seq_total(m_sound)) m_active = 1'b0;
            end
            m_hist = playsound;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("cyc_busy", 32'(busy), 32'(m_active && m_t < seq_total(m_sound)));
            check("cyc_done", 32'(sound_done), 32'(m_active && m_t == seq_total(m_sound)));
            check("cyc_audio", 32'(audio_out), 32'(m_active && exp_audio(m_sound, m_t)));
            check("cyc_cur_sound", 32'(cur_sound), 32'(m_sound));
            if (sound_done) done_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic play_measure(input logic [1:0] sel, output int len);
        @(negedge clk); playsound = 1'b1; soundselector = sel;
        @(negedge clk); playsound = 1'b0;
        len = 0;
        while (busy && len < 2000) begin
            aud[len] = audio_out;
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        int len, d0, b0, ones;
        reset = 1'b1; playsound = 1'b1; soundselector = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_audio", 32'(audio_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(sound_done), 0);
        check("rst_cur_sound", 32'(cur_sound), 0);
        repeat (20) @(negedge clk);
        check("held_through_reset_busy", busy_cnt, 0);
        playsound = 1'b0;
        @(negedge clk);

        d0 = done_cnt;
        play_measure(2'd0, len);
        check("ui_len", len, 64);
        check("ui_done_pulse", 32'(sound_done), 1);
        check("ui_aud15", 32'(aud[15]), 0);
        check("ui_aud16", 32'(aud[16]), 1);
        check("ui_aud32", 32'(aud[32]), 0);
        check("ui_aud48", 32'(aud[48]), 1);
        check("ui_cur_sound", 32'(cur_sound), 0);
        @(negedge clk);
        check("ui_done_count", done_cnt - d0, 1);

        d0 = done_cnt;
        play_measure(2'd1, len);
        check("nl_len", len, 448);
        check("nl_aud23", 32'(aud[23]), 0);
        check("nl_aud24", 32'(aud[24]), 1);
        check("nl_aud128", 32'(aud[128]), 0);
        check("nl_aud144", 32'(aud[144]), 1);
        check("nl_aud256", 32'(aud[256]), 0);
        check("nl_aud264", 32'(aud[264]), 1);
        check("nl_cur_sound", 32'(cur_sound), 1);
        @(negedge clk);
        check("nl_done_count", done_cnt - d0, 1);

        d0 = done_cnt;
        play_measure(2'd2, len);
        check("cr_len", len, 448);
        check("cr_aud27", 32'(aud[27]), 0);
        check("cr_aud28", 32'(aud[28]), 1);
        ones = 0;
        for (int i = 128; i < 192; i++) if (aud[i]) ones++;
        check("cr_rest_silent", ones, 0);
        check("cr_aud223", 32'(aud[223]), 0);
        check("cr_aud224", 32'(aud[224]), 1);
        @(negedge clk);
        check("cr_done_count", done_cnt - d0, 1);

        d0 = done_cnt;
        @(negedge clk); playsound = 1'b1; soundselector = 2'd3;
        @(negedge clk); playsound = 1'b0;
        repeat (99) @(negedge clk);
        playsound = 1'b1; soundselector = 2'd0;
        @(negedge clk); playsound = 1'b0;
        len = 0;
        while (busy && len < 2000) begin len++; @(negedge clk); end
        check("pre_len", len, 64);
        check("pre_cur_sound", 32'(cur_sound), 0);
        @(negedge clk);
        check("pre_done_count", done_cnt - d0, 1);

        d0 = done_cnt; b0 = busy_cnt;
        @(negedge clk); playsound = 1'b1; soundselector = 2'd0;
        repeat (500) @(negedge clk);
        playsound = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_busy_cycles", busy_cnt - b0, 64);
        check("hold_done_count", done_cnt - d0, 1);

        @(negedge clk); playsound = 1'b1; soundselector = 2'd1;
        @(negedge clk); playsound = 1'b0;
        repeat (30) @(negedge clk);
        check("ar_aud_before", 32'(audio_out), 1);
        #2 reset = 1'b1;
        #1;
        check("ar_audio", 32'(audio_out), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_done", 32'(sound_done), 0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (500) @(negedge clk);
        check("ar_no_done_after", done_cnt - d0, 0);
        check("ar_busy_after", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
